// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: FSM encoding,
// burst-length limits and the beat-counter width that covers them.
package mux_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } sched_state_e;

  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 16;

  // Counter holds 0..MAX_BURST_MAX-1
  localparam int CNT_W = 4;

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// Combinational round-robin search: first set bit of (req & ~excl) starting
// at ptr+1 and wrapping N-1 -> 0; ptr itself is the last candidate visited.
module rr_pick
  import mux_sched_pkg::*;
#(
  parameter int N    = 32,
  parameter int SELW = 5
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic [N-1:0]    excl,
  output logic [SELW-1:0] idx,
  output logic            found
);

  logic [N-1:0] req_eff;

  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % N;
    return SELW'(s);
  endfunction

  assign req_eff = req & ~excl;

  // Walk from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req_eff[wrap_idx(ptr, i)]) begin
        idx   = wrap_idx(ptr, i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler that owns the select of an N:1 mux tree, granting one
// requester at a time for bursts of up to MAX_BURST beats.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int N         = 32,
  parameter int SELW      = 5,
  parameter int MAX_BURST = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    REQ,
  input  logic            READY,
  output logic [SELW-1:0] SEL,
  output logic [N-1:0]    GNT,
  output logic            VALID,
  output logic            LAST
);

  if (MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX) begin : g_bad_burst
    $error("mux_rr_sched: MAX_BURST out of range");
  end
  if (SELW != $clog2(N)) begin : g_bad_selw
    $error("mux_rr_sched: SELW must equal clog2(N)");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [SELW-1:0]  PTR_RST  = SELW'(N - 1);

  sched_state_e    state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            busy;
  logic            own_req;
  logic            xfer;
  logic            rel;
  logic [SELW-1:0] pick_ptr;
  logic [N-1:0]    pick_excl;
  logic [SELW-1:0] pick_idx;
  logic            pick_found;

  assign busy    = (state_q == ST_BUSY);
  assign own_req = REQ[sel_q];
  assign VALID   = busy & own_req;
  assign LAST    = busy & (cnt_q == LAST_CNT);
  assign xfer    = VALID & READY;
  assign rel     = busy & (~own_req | (xfer & LAST));

  assign SEL = sel_q;
  assign GNT = gnt_q;

  // On release the search restarts after the released owner, which is only
  // eligible again when nobody else is asking.
  always_comb begin
    pick_ptr  = ptr_q;
    pick_excl = '0;
    if (rel) begin
      pick_ptr = sel_q;
      if ((REQ & ~gnt_q) != '0) begin
        pick_excl = gnt_q;
      end
    end
  end

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req   (REQ),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (rel) begin
          ptr_d = sel_q;
          cnt_d = '0;
          if (pick_found) begin
            gnt_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
            sel_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            sel_d   = '0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
